// File: rtl/mod_n_updown_counter.sv
//-----------------------------------------------------------------------------
// mod_n_updown_counter
//
// Purpose:
//   Modulo-N up/down counter with a synchronous parallel load. The count range
//   is 0..MODULUS-1. Out-of-range loads are rejected and flagged. Wrap events
//   in either direction are flagged with one-cycle pulses. All outputs are
//   registered. An asynchronous reset clears the count and the pulses at once.
//
// Parameters:
//   WIDTH        - counter and data bus width in bits (>= 1)
//   MODULUS      - number of count states, 2 .. 2**WIDTH
//   STEP_UP_ONLY - 1: ignore mode and always count up
//
// Ports:
//   clock    in   1      sole clock; all state updates happen on posedge
//   rst      in   1      asynchronous active-high reset
//   load     in   1      synchronous parallel load request (highest priority)
//   datain   in   WIDTH  load value
//   mode     in   1      direction: 1 = up, 0 = down
//   enable   in   1      count enable; 0 holds the count
//   dataout  out  WIDTH  current count, registered
//   carry    out  1      one-cycle pulse on the up-wrap MODULUS-1 -> 0
//   borrow   out  1      one-cycle pulse on the down-wrap 0 -> MODULUS-1
//   load_err out  1      one-cycle pulse on a rejected out-of-range load
//-----------------------------------------------------------------------------
module mod_n_updown_counter #(
    parameter int WIDTH        = 4,
    parameter int MODULUS      = 12,
    parameter bit STEP_UP_ONLY = 1'b0
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] datain,
    input  logic             mode,
    input  logic             enable,
    output logic [WIDTH-1:0] dataout,
    output logic             carry,
    output logic             borrow,
    output logic             load_err
);

    //-------------------------------------------------------------------------
    // Parameter sanity. A 64-bit shift keeps the upper bound meaningful even
    // for wide counters where 2**WIDTH would overflow a 32-bit int.
    //-------------------------------------------------------------------------
    generate
        if (WIDTH < 1) begin : g_bad_width
            $error("mod_n_updown_counter: WIDTH must be at least 1");
        end
        if (MODULUS < 2) begin : g_bad_mod_low
            $error("mod_n_updown_counter: MODULUS must be at least 2");
        end
        if (64'(MODULUS) > (64'd1 << WIDTH)) begin : g_bad_mod_high
            $error("mod_n_updown_counter: MODULUS must not exceed 2**WIDTH");
        end
    endgenerate

    //-------------------------------------------------------------------------
    // Constants
    //-------------------------------------------------------------------------
    // Terminal count, exactly representable in WIDTH bits.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // MODULUS itself may equal 2**WIDTH, so the range check uses one extra bit.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    //-------------------------------------------------------------------------
    // State
    //-------------------------------------------------------------------------
    logic [WIDTH-1:0] r_count;
    logic             r_carry;
    logic             r_borrow;
    logic             r_load_err;

    //-------------------------------------------------------------------------
    // Decode of the current state and the sampled inputs
    //-------------------------------------------------------------------------
    logic             w_load_ok;
    logic             w_dir_up;
    logic             w_at_max;
    logic             w_at_zero;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;

    // With MODULUS == 2**WIDTH every datain is in range, so this folds to 1
    // and load_err can never assert.
    assign w_load_ok = ({1'b0, datain} < MOD_EXT);

    assign w_dir_up  = STEP_UP_ONLY ? 1'b1 : mode;
    assign w_at_max  = (r_count == MAX_VAL);
    assign w_at_zero = (r_count == '0);

    // Plain WIDTH-bit increment/decrement. They are only selected away from
    // the boundaries, so their natural wrap is never observed.
    assign w_inc = r_count + WIDTH'(1);
    assign w_dec = r_count - WIDTH'(1);

    //-------------------------------------------------------------------------
    // Next-state selection: load > enable > hold
    //-------------------------------------------------------------------------
    logic [WIDTH-1:0] w_count_next;
    logic             w_carry_next;
    logic             w_borrow_next;
    logic             w_load_err_next;

    always_comb begin
        w_count_next    = r_count;
        w_carry_next    = 1'b0;
        w_borrow_next   = 1'b0;
        w_load_err_next = 1'b0;

        if (load) begin
            // A rejected load still consumes the edge: no count happens even
            // with enable high.
            if (w_load_ok) begin
                w_count_next = datain;
            end else begin
                w_load_err_next = 1'b1;
            end
        end else if (enable) begin
            if (w_dir_up) begin
                if (w_at_max) begin
                    w_count_next = '0;
                    w_carry_next = 1'b1;
                end else begin
                    w_count_next = w_inc;
                end
            end else begin
                if (w_at_zero) begin
                    w_count_next  = MAX_VAL;
                    w_borrow_next = 1'b1;
                end else begin
                    w_count_next = w_dec;
                end
            end
        end
    end

    //-------------------------------------------------------------------------
    // Registers. Reset is asynchronous so the outputs clear as soon as rst
    // rises, discarding whatever update was pending for the next edge.
    //-------------------------------------------------------------------------
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_count    <= '0;
            r_carry    <= 1'b0;
            r_borrow   <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_count    <= w_count_next;
            r_carry    <= w_carry_next;
            r_borrow   <= w_borrow_next;
            r_load_err <= w_load_err_next;
        end
    end

    //-------------------------------------------------------------------------
    // Outputs
    //-------------------------------------------------------------------------
    assign dataout  = r_count;
    assign carry    = r_carry;
    assign borrow   = r_borrow;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_mod_n_updown_counter.sv
//-----------------------------------------------------------------------------
// tb_mod_n_updown_counter
//
// Drives three counter instances with one shared stimulus stream:
//   inst 0: WIDTH=4 MODULUS=12
//   inst 1: WIDTH=4 MODULUS=16
//   inst 2: WIDTH=4 MODULUS=16 STEP_UP_ONLY=1
// A reference model computes each instance's expected outputs with modular
// integer arithmetic; expectations are queued by the stimulus process and a
// separate monitor pops and compares them after every rising edge.
//-----------------------------------------------------------------------------
module tb_mod_n_updown_counter;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       mode = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] datain = 4'd0;

    logic [3:0] dout_a, dout_b, dout_c;
    logic       carry_a, carry_b, carry_c;
    logic       borrow_a, borrow_b, borrow_c;
    logic       lerr_a, lerr_b, lerr_c;

    always #5 clock = ~clock;

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(12), .STEP_UP_ONLY(1'b0)) dut_a (
        .clock(clock), .rst(rst), .load(load), .datain(datain), .mode(mode),
        .enable(enable), .dataout(dout_a), .carry(carry_a), .borrow(borrow_a),
        .load_err(lerr_a));

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(16), .STEP_UP_ONLY(1'b0)) dut_b (
        .clock(clock), .rst(rst), .load(load), .datain(datain), .mode(mode),
        .enable(enable), .dataout(dout_b), .carry(carry_b), .borrow(borrow_b),
        .load_err(lerr_b));

    mod_n_updown_counter #(.WIDTH(4), .MODULUS(16), .STEP_UP_ONLY(1'b1)) dut_c (
        .clock(clock), .rst(rst), .load(load), .datain(datain), .mode(mode),
        .enable(enable), .dataout(dout_c), .carry(carry_c), .borrow(borrow_c),
        .load_err(lerr_c));

    // Observed output bundle per instance: {dataout, carry, borrow, load_err}
    logic [6:0] obs [3];
    assign obs[0] = {dout_a, carry_a, borrow_a, lerr_a};
    assign obs[1] = {dout_b, carry_b, borrow_b, lerr_b};
    assign obs[2] = {dout_c, carry_c, borrow_c, lerr_c};

    // One queued entry holds the expected bundle for all three instances.
    typedef logic [20:0] exp_t;
    exp_t q [$];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int cnt    [3] = '{0, 0, 0};
    int mods   [3] = '{12, 16, 16};
    bit uponly [3] = '{1'b0, 1'b0, 1'b1};
    string names [3] = '{"m12", "m16", "m16up"};

    function automatic logic [6:0] model_step(int k, bit r, bit ld, int din, bit md, bit en);
        int m;
        bit c, b, e, up;
        m = mods[k];
        c = 1'b0; b = 1'b0; e = 1'b0;
        if (r) begin
            cnt[k] = 0;
        end else if (ld) begin
            if (din < m) cnt[k] = din;
            else e = 1'b1;
        end else if (en) begin
            up = uponly[k] | md;
            if (up) begin
                c = (cnt[k] + 1 == m);
                cnt[k] = (cnt[k] + 1) % m;
            end else begin
                b = (cnt[k] == 0);
                cnt[k] = (cnt[k] + m - 1) % m;
            end
        end
        return {4'(cnt[k]), c, b, e};
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue the outputs
    // expected after the following rising edge.
    task automatic step(input bit r, input bit ld, input int din, input bit md, input bit en);
        exp_t x;
        @(negedge clock);
        rst    = r;
        load   = ld;
        datain = 4'(din);
        mode   = md;
        enable = en;
        for (int k = 0; k < 3; k++) begin
            x[7*k +: 7] = model_step(k, r, ld, din, md, en);
        end
        q.push_back(x);
    endtask

    // Immediate check that every output is cleared (used right after rst rises).
    task automatic check_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (obs[k] !== 7'd0) begin
                errors++;
                $display("FAIL %s %s: got dout=%0d c=%0b b=%0b e=%0b, want all zero",
                         tag, names[k], obs[k][6:3], obs[k][2], obs[k][1], obs[k][0]);
            end
        end
    endtask

    // Assert reset between edges, after the previous edge was checked.
    task automatic async_reset(input string tag);
        @(posedge clock);
        #3;
        rst = 1'b1;
        #1;
        check_zero(tag);
        for (int k = 0; k < 3; k++) cnt[k] = 0;
    endtask

    // Monitor: one comparison per instance per queued transaction.
    always @(posedge clock) begin
        exp_t x;
        #1;
        if (q.size() > 0) begin
            x = q.pop_front();
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (obs[k] !== x[7*k +: 7]) begin
                    errors++;
                    $display("FAIL cycle %s: got dout=%0d c=%0b b=%0b e=%0b, want dout=%0d c=%0b b=%0b e=%0b",
                             names[k], obs[k][6:3], obs[k][2], obs[k][1], obs[k][0],
                             x[7*k+3 +: 4], x[7*k+2], x[7*k+1], x[7*k]);
                end
            end
            $display("t=%0t rst=%0b ld=%0b din=%0d md=%0b en=%0b | m12=%0d/%0b%0b%0b m16=%0d/%0b%0b%0b m16up=%0d/%0b%0b%0b",
                     $time, rst, load, datain, mode, enable,
                     dout_a, carry_a, borrow_a, lerr_a,
                     dout_b, carry_b, borrow_b, lerr_b,
                     dout_c, carry_c, borrow_c, lerr_c);
        end
    end

    initial begin
        // Reset takes effect before any clock edge.
        #1 rst = 1'b1;
        #1 check_zero("reset_state");
        // Load/enable must be ignored while reset is held.
        step(1, 1, 5, 1, 1);
        step(1, 0, 0, 1, 1);

        // Load 5, count up 7 cycles through the wrap, then one more.
        step(0, 1, 5, 1, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 1);

        // Load 0 and count down across the wrap.
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Out-of-range load with enable high: count holds on m12.
        step(0, 1, 4, 1, 0);
        step(0, 1, 13, 1, 1);
        step(0, 0, 0, 1, 0);

        // Load beats enable at terminal count; then enable-only wraps.
        step(0, 1, 11, 1, 0);
        step(0, 1, 11, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0);

        // Direction reversal at the boundary: 0 -> up, back down, down again.
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);

        // Counting up at 7, reset between edges, hold, release.
        step(0, 1, 6, 1, 0);
        step(0, 0, 0, 1, 1);
        async_reset("rst_mid_count");
        step(1, 1, 9, 1, 1);
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);

        // Reset during a wrap pulse must drop the pulse at once.
        step(0, 1, 11, 1, 0);
        step(0, 0, 0, 1, 1);
        async_reset("rst_during_wrap");
        step(0, 0, 0, 1, 1);

        // Count 15 -> 0 on the full-range instances.
        step(0, 1, 15, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 1, 15, 1, 0);
        step(0, 0, 0, 1, 1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit r, ld, md, en;
            int din;
            r   = ($urandom_range(0, 39) == 0);
            ld  = ($urandom_range(0, 5) == 0);
            din = int'($urandom_range(0, 15));
            md  = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 3) != 0);
            step(r, ld, din, md, en);
        end
        step(0, 0, 0, 0, 0);

        // Let the monitor drain; anything left means it stopped seeing edges.
        repeat (3) @(posedge clock);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
